id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 128 ++++++++++++
 tb/tb_id_ex_stage.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding.
// Holds the decoded instruction for one cycle and resolves operand A/B,
// the store data and the shift amount from the stored fields plus the
// forwarding sources presented by later pipeline stages.
//
// Pipeline control: each rising edge either resets (rst low), loads a
// bubble (flush), holds every stored field (stall) or captures the ID
// inputs. Flush beats stall, and reset beats both. There is no ready
// back-pressure; stall is the only hold mechanism, and valid marks a real
// instruction in the EX slot.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] id_pc,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_alu_src,
    input  logic [3:0]      id_alu_op,
    input  logic            id_reg_write,
    input  logic            exmem_reg_write,
    input  logic [REGW-1:0] exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_reg_write,
    input  logic [REGW-1:0] memwb_rd,
    input  logic [XLEN-1:0] memwb_result,
    output logic            ex_valid,
    output logic [3:0]      ex_alu_op,
    output logic            ex_reg_write,
    output logic [REGW-1:0] ex_rd,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_alu_a,
    output logic [XLEN-1:0] ex_alu_b,
    output logic [XLEN-1:0] ex_store_data,
    output logic [REGW-1:0] ex_shamt
);

    logic            valid_q;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs2_data_q;
    logic [XLEN-1:0] imm_q;
    logic [XLEN-1:0] pc_q;
    logic [REGW-1:0] rs1_q;
    logic [REGW-1:0] rs2_q;
    logic [REGW-1:0] rd_q;
    logic            alu_src_q;
    logic [3:0]      alu_op_q;
    logic            reg_write_q;

    logic [XLEN-1:0] fa;
    logic [XLEN-1:0] fb;
    logic [XLEN-1:0] alu_b;

    // Pipeline register: reset, then bubble, then hold, else capture.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            // Reset and bubble clear the same fields, so a stalled
            // instruction is discarded either way.
            valid_q     <= 1'b0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            pc_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            alu_src_q   <= 1'b0;
            alu_op_q    <= '0;
            reg_write_q <= 1'b0;
        end else if (!stall) begin
            valid_q     <= id_valid;
            rs1_data_q  <= id_rs1_data;
            rs2_data_q  <= id_rs2_data;
            imm_q       <= id_imm;
            pc_q        <= id_pc;
            rs1_q       <= id_rs1;
            rs2_q       <= id_rs2;
            rd_q        <= id_rd;
            alu_src_q   <= id_alu_src;
            alu_op_q    <= id_alu_op;
            reg_write_q <= id_reg_write;
        end
    end

    // Operand forwarding: youngest producer (EX/MEM) first, x0 never forwarded.
    // Driven only by stored indices and live forward inputs, so it tracks
    // producers that complete while this stage is stalled.
    always_comb begin
        fa = rs1_data_q;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs1_q)) begin
            fa = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs1_q)) begin
            fa = memwb_result;
        end

        fb = rs2_data_q;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs2_q)) begin
            fb = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs2_q)) begin
            fb = memwb_result;
        end

        alu_b = alu_src_q ? imm_q : fb;
    end

    assign ex_valid      = valid_q;
    assign ex_alu_op     = alu_op_q;
    // A non-valid slot must never write back, whatever reg_write was captured.
    assign ex_reg_write  = valid_q & reg_write_q;
    assign ex_rd         = rd_q;
    assign ex_pc         = pc_q;
    assign ex_alu_a      = fa;
    assign ex_alu_b      = alu_b;
    // Store data is the register operand even when B selects the immediate.
    assign ex_store_data = fb;
    // Low bits only: the shifter never sees amounts beyond 2**REGW-1.
    assign ex_shamt      = alu_b[REGW-1:0];

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: table of directed vectors with
// hand-derived expectations, random vectors against a reference model,
// and hand-written stall / flush / reset sequences.
module tb_id_ex_stage;

    localparam int XLEN = 32;
    localparam int REGW = 5;
    localparam int OW   = 1 + 4 + 1 + REGW + 4 * XLEN + REGW;

    typedef struct {
        logic        valid;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        src;
        logic [3:0]  op;
        logic        rw;
        logic        ew;
        logic [4:0]  erd;
        logic [31:0] eres;
        logic        mw;
        logic [4:0]  mrd;
        logic [31:0] mres;
        logic [OW-1:0] exp;
    } vec_t;

    logic            clk;
    logic            rst;
    logic            stall;
    logic            flush;
    logic            id_valid;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [XLEN-1:0] id_pc;
    logic [REGW-1:0] id_rs1;
    logic [REGW-1:0] id_rs2;
    logic [REGW-1:0] id_rd;
    logic            id_alu_src;
    logic [3:0]      id_alu_op;
    logic            id_reg_write;
    logic            exmem_reg_write;
    logic [REGW-1:0] exmem_rd;
    logic [XLEN-1:0] exmem_result;
    logic            memwb_reg_write;
    logic [REGW-1:0] memwb_rd;
    logic [XLEN-1:0] memwb_result;
    logic            ex_valid;
    logic [3:0]      ex_alu_op;
    logic            ex_reg_write;
    logic [REGW-1:0] ex_rd;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_alu_a;
    logic [XLEN-1:0] ex_alu_b;
    logic [XLEN-1:0] ex_store_data;
    logic [REGW-1:0] ex_shamt;

    logic [OW-1:0] act;
    logic [OW-1:0] exp_q[$];
    int            n_checks;
    int            n_fail;

    id_ex_stage #(.XLEN(XLEN), .REGW(REGW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_alu_src(id_alu_src), .id_alu_op(id_alu_op), .id_reg_write(id_reg_write),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_reg_write(ex_reg_write),
        .ex_rd(ex_rd), .ex_pc(ex_pc), .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b),
        .ex_store_data(ex_store_data), .ex_shamt(ex_shamt)
    );

    assign act = {ex_valid, ex_alu_op, ex_reg_write, ex_rd, ex_pc,
                  ex_alu_a, ex_alu_b, ex_store_data, ex_shamt};

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [OW-1:0] pack(input logic v, input logic [3:0] op, input logic rw,
                                           input logic [4:0] rd, input logic [31:0] pc,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] sd, input logic [4:0] sh);
        return {v, op, rw, rd, pc, a, b, sd, sh};
    endfunction

    function automatic vec_t mk(input logic v, input logic [31:0] rs1d, input logic [31:0] rs2d,
                                input logic [31:0] imm, input logic [31:0] pc,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic src, input logic [3:0] op, input logic rw,
                                input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                                input logic mw, input logic [4:0] mrd, input logic [31:0] mres,
                                input logic [OW-1:0] exp);
        vec_t t;
        t.valid = v;  t.rs1d = rs1d; t.rs2d = rs2d; t.imm = imm; t.pc = pc;
        t.rs1 = rs1;  t.rs2 = rs2;   t.rd = rd;     t.src = src; t.op = op; t.rw = rw;
        t.ew = ew;    t.erd = erd;   t.eres = eres;
        t.mw = mw;    t.mrd = mrd;   t.mres = mres;
        t.exp = exp;
        return t;
    endfunction

    // Reference behaviour written from the block's functional description.
    function automatic logic [OW-1:0] model(input vec_t t);
        logic [31:0] fa;
        logic [31:0] fb;
        logic [31:0] b;
        if (t.ew && t.erd != 5'd0 && t.erd == t.rs1)      fa = t.eres;
        else if (t.mw && t.mrd != 5'd0 && t.mrd == t.rs1) fa = t.mres;
        else                                               fa = t.rs1d;
        if (t.ew && t.erd != 5'd0 && t.erd == t.rs2)      fb = t.eres;
        else if (t.mw && t.mrd != 5'd0 && t.mrd == t.rs2) fb = t.mres;
        else                                               fb = t.rs2d;
        b = t.src ? t.imm : fb;
        return pack(t.valid, t.op, t.valid & t.rw, t.rd, t.pc, fa, b, fb, b[4:0]);
    endfunction

    task automatic check(input string name, input logic [OW-1:0] got, input logic [OW-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic drive_id(input vec_t t);
        id_valid     = t.valid;
        id_rs1_data  = t.rs1d;
        id_rs2_data  = t.rs2d;
        id_imm       = t.imm;
        id_pc        = t.pc;
        id_rs1       = t.rs1;
        id_rs2       = t.rs2;
        id_rd        = t.rd;
        id_alu_src   = t.src;
        id_alu_op    = t.op;
        id_reg_write = t.rw;
    endtask

    task automatic drive_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                             input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
        exmem_reg_write = ew;
        exmem_rd        = erd;
        exmem_result    = eres;
        memwb_reg_write = mw;
        memwb_rd        = mrd;
        memwb_result    = mres;
    endtask

    task automatic drive_rand_id();
        id_valid     = 1'($urandom_range(0, 1));
        id_rs1_data  = $urandom;
        id_rs2_data  = $urandom;
        id_imm       = $urandom;
        id_pc        = $urandom;
        id_rs1       = 5'($urandom_range(0, 31));
        id_rs2       = 5'($urandom_range(0, 31));
        id_rd        = 5'($urandom_range(0, 31));
        id_alu_src   = 1'($urandom_range(0, 1));
        id_alu_op    = 4'($urandom_range(0, 15));
        id_reg_write = 1'($urandom_range(0, 1));
    endtask

    // Drive one vector at the falling edge, expect it one edge later.
    task automatic apply_vec(input string name, input vec_t t);
        @(negedge clk);
        drive_id(t);
        drive_fwd(t.ew, t.erd, t.eres, t.mw, t.mrd, t.mres);
        exp_q.push_back(t.exp);
        @(posedge clk);
        #1;
        check(name, act, exp_q.pop_front());
    endtask

    // Expect current outputs after the next edge, with whatever is driven now.
    task automatic edge_expect(input string name, input logic [OW-1:0] want);
        exp_q.push_back(want);
        @(posedge clk);
        #1;
        check(name, act, exp_q.pop_front());
    endtask

    vec_t  vecs[7];
    string vnames[7];
    vec_t  v;
    vec_t  hold_v;

    initial begin
        n_checks = 0;
        n_fail   = 0;

        vnames[0] = "basic_capture";
        vecs[0] = mk(1, 32'hF0, 32'h55, 32'h24, 32'h40, 5'd1, 5'd2, 5'd3, 1, 4'd2, 1,
                     0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                     pack(1, 4'd2, 1, 5'd3, 32'h40, 32'hF0, 32'h24, 32'h55, 5'd4));
        vnames[1] = "fwd_exmem_priority";
        vecs[1] = mk(1, 32'h11, 32'h22, 32'h0, 32'h44, 5'd5, 5'd6, 5'd9, 0, 4'd1, 1,
                     1, 5'd5, 32'hAAAA_0000, 1, 5'd5, 32'h1234,
                     pack(1, 4'd1, 1, 5'd9, 32'h44, 32'hAAAA_0000, 32'h22, 32'h22, 5'd2));
        vnames[2] = "fwd_memwb";
        vecs[2] = mk(1, 32'h11, 32'h22, 32'h0, 32'h44, 5'd5, 5'd6, 5'd9, 0, 4'd1, 1,
                     0, 5'd5, 32'hAAAA_0000, 1, 5'd5, 32'h1234,
                     pack(1, 4'd1, 1, 5'd9, 32'h44, 32'h1234, 32'h22, 32'h22, 5'd2));
        vnames[3] = "x0_guard";
        vecs[3] = mk(1, 32'h3, 32'h77, 32'h0, 32'h48, 5'd0, 5'd0, 5'd2, 0, 4'd0, 1,
                     1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 32'hFFFF_FFFF,
                     pack(1, 4'd0, 1, 5'd2, 32'h48, 32'h3, 32'h77, 32'h77, 5'h17));
        vnames[4] = "store_fwd_imm_b";
        vecs[4] = mk(1, 32'h9, 32'h5, 32'h3F, 32'h4C, 5'd4, 5'd8, 5'd10, 1, 4'd6, 0,
                     1, 5'd8, 32'hDEAD_BEEF, 1, 5'd4, 32'hCAFE,
                     pack(1, 4'd6, 0, 5'd10, 32'h4C, 32'hCAFE, 32'h3F, 32'hDEAD_BEEF, 5'h1F));
        vnames[5] = "invalid_no_write";
        vecs[5] = mk(0, 32'h10, 32'h20, 32'h0, 32'h50, 5'd1, 5'd2, 5'd12, 0, 4'd3, 1,
                     0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                     pack(0, 4'd3, 0, 5'd12, 32'h50, 32'h10, 32'h20, 32'h20, 5'd0));
        vnames[6] = "shamt_truncate";
        vecs[6] = mk(1, 32'h0, 32'h1, 32'hFFFF_FFE5, 32'h54, 5'd0, 5'd0, 5'd1, 1, 4'd7, 0,
                     0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                     pack(1, 4'd7, 0, 5'd1, 32'h54, 32'h0, 32'hFFFF_FFE5, 32'h1, 5'd5));

        // Reset with stall and flush asserted and junk on the ID inputs.
        rst   = 1'b0;
        stall = 1'b1;
        flush = 1'b1;
        drive_rand_id();
        drive_fwd(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", act, '0);
        @(negedge clk);
        rst   = 1'b1;
        stall = 1'b0;
        flush = 1'b0;

        for (int i = 0; i < 7; i++) begin
            apply_vec(vnames[i], vecs[i]);
        end

        // Random vectors with small register indices so forwarding hits often.
        for (int i = 0; i < 24; i++) begin
            v = mk(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom,
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom, '0);
            v.exp = model(v);
            apply_vec("random", v);
        end

        // Stall holds a captured instruction while ID inputs change.
        hold_v = mk(1, 32'h1, 32'h2, 32'h8, 32'h100, 5'd3, 5'd4, 5'd4, 0, 4'd5, 1,
                    0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                    pack(1, 4'd5, 1, 5'd4, 32'h100, 32'h1, 32'h2, 32'h2, 5'd2));
        apply_vec("stall_capture", hold_v);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stall = 1'b1;
            drive_rand_id();
            edge_expect("stall_hold", hold_v.exp);
            check("stall_pc", OW'(ex_pc), OW'(32'h100));
        end

        // Forwarding keeps tracking while stalled.
        @(negedge clk);
        drive_fwd(1, 5'd3, 32'h5555, 0, 5'd0, 32'h0);
        #1;
        check("stall_fwd_a", act, pack(1, 4'd5, 1, 5'd4, 32'h100, 32'h5555, 32'h2, 32'h2, 5'd2));

        // Flush beats stall; bubble must not pick up an x0 forward.
        @(negedge clk);
        flush = 1'b1;
        drive_fwd(1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 32'hFFFF_FFFF);
        edge_expect("flush_over_stall", '0);
        @(negedge clk);
        flush = 1'b0;
        stall = 1'b0;

        // Reset during a stall discards the held instruction.
        v = mk(1, 32'hA, 32'hB, 32'hC, 32'h200, 5'd1, 5'd2, 5'd7, 0, 4'd4, 1,
               0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
               pack(1, 4'd4, 1, 5'd7, 32'h200, 32'hA, 32'hB, 32'hB, 5'hB));
        apply_vec("pre_reset_capture", v);
        @(negedge clk);
        stall = 1'b1;
        rst   = 1'b0;
        drive_rand_id();
        edge_expect("reset_mid_stall", '0);
        @(negedge clk);
        rst   = 1'b1;
        stall = 1'b0;
        v = mk(1, 32'h31, 32'h32, 32'h33, 32'h300, 5'd6, 5'd7, 5'd8, 1, 4'd9, 1,
               0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
               pack(1, 4'd9, 1, 5'd8, 32'h300, 32'h31, 32'h33, 32'h32, 5'h13));
        drive_id(v);
        edge_expect("capture_after_reset", v.exp);

        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
